// File: rtl/fp32_uart_frame_rx.sv
// UART receiver collecting FRAME_BYTES 8N1/8E1/8O1 characters into one word,
// offered downstream through a single-entry ready/valid holding register.
module fp32_uart_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FRAME_BYTES  = 12,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                     CLK_I,
    input  logic                     RSTL_I,
    input  logic                     UART_RX_I,
    input  logic                     RX_READY_I,
    output logic                     RX_VALID_O,
    output logic [8*FRAME_BYTES-1:0] RX_DATA_O,
    output logic                     FRAME_ERR_O,
    output logic                     PARITY_ERR_O,
    output logic                     OVERRUN_O,
    output logic                     TIMEOUT_O,
    output logic                     BUSY_O
);

    localparam int unsigned CLK_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [CLK_W-1:0]  BIT_END   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0]  HALF_END  = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_END    = TO_W'(TO_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_RECOVER
    } state_t;

    logic                     r_sync_meta, r_rxs;
    state_t                   r_state, w_state_n;
    logic [CLK_W-1:0]         r_bit_clk, w_bit_clk_n;
    logic [2:0]               r_bit_idx, w_bit_idx_n;
    logic [BYTE_W-1:0]        r_byte_idx, w_byte_idx_n;
    logic [7:0]               r_byte, w_byte_n;
    logic                     r_par_err, w_par_err_n;
    logic [8*FRAME_BYTES-1:0] r_asm, w_asm_n;
    logic [TO_W-1:0]          r_to_cnt, w_to_cnt_n;
    logic                     r_commit, w_commit_n;
    logic                     r_valid, w_valid_n;
    logic [8*FRAME_BYTES-1:0] r_data, w_data_n;
    logic                     r_ferr, w_ferr_n;
    logic                     r_perr, w_perr_n;
    logic                     r_ovr, w_ovr_n;
    logic                     r_tout, w_tout_n;

    always_comb begin
        w_state_n    = r_state;
        w_bit_clk_n  = r_bit_clk;
        w_bit_idx_n  = r_bit_idx;
        w_byte_idx_n = r_byte_idx;
        w_byte_n     = r_byte;
        w_par_err_n  = r_par_err;
        w_asm_n      = r_asm;
        w_to_cnt_n   = '0;
        w_commit_n   = 1'b0;
        w_ferr_n     = 1'b0;
        w_perr_n     = 1'b0;
        w_tout_n     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_bit_clk_n = '0;
                w_bit_idx_n = '0;
                w_par_err_n = 1'b0;
                // Timeout counter only runs while a partial frame is pending;
                // leaving IDLE always means a start edge, which clears it.
                if (!r_rxs) begin
                    w_state_n = ST_START;
                end else if (r_byte_idx != '0) begin
                    if (r_to_cnt == TO_END) begin
                        w_tout_n     = 1'b1;
                        w_byte_idx_n = '0;
                    end else begin
                        w_to_cnt_n = r_to_cnt + 1'b1;
                    end
                end
            end
            ST_START: begin
                if (r_bit_clk == HALF_END) begin
                    w_bit_clk_n = '0;
                    w_state_n   = r_rxs ? ST_IDLE : ST_DATA;
                end else begin
                    w_bit_clk_n = r_bit_clk + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_bit_clk == BIT_END) begin
                    w_bit_clk_n           = '0;
                    w_byte_n[r_bit_idx]   = r_rxs;
                    w_bit_idx_n           = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end else begin
                    w_bit_clk_n = r_bit_clk + 1'b1;
                end
            end
            ST_PARITY: begin
                if (r_bit_clk == BIT_END) begin
                    w_bit_clk_n = '0;
                    w_par_err_n = (r_rxs != ((^r_byte) ^ PARITY_ODD));
                    w_state_n   = ST_STOP;
                end else begin
                    w_bit_clk_n = r_bit_clk + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_bit_clk == BIT_END) begin
                    w_bit_clk_n = '0;
                    if (!r_rxs) begin
                        w_ferr_n     = 1'b1;
                        w_byte_idx_n = '0;
                        w_state_n    = ST_RECOVER;
                    end else if (r_par_err) begin
                        w_perr_n     = 1'b1;
                        w_byte_idx_n = '0;
                        w_state_n    = ST_IDLE;
                    end else begin
                        for (int unsigned k = 0; k < FRAME_BYTES; k++) begin
                            if (r_byte_idx == BYTE_W'(k)) w_asm_n[8*k +: 8] = r_byte;
                        end
                        if (r_byte_idx == LAST_BYTE) begin
                            w_byte_idx_n = '0;
                            w_commit_n   = 1'b1;
                        end else begin
                            w_byte_idx_n = r_byte_idx + 1'b1;
                        end
                        w_state_n = ST_IDLE;
                    end
                end else begin
                    w_bit_clk_n = r_bit_clk + 1'b1;
                end
            end
            ST_RECOVER: begin
                if (r_rxs) w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // A commit may replace the held frame in the very cycle it is consumed.
    always_comb begin
        w_valid_n = r_valid;
        w_data_n  = r_data;
        w_ovr_n   = 1'b0;
        if (r_valid && RX_READY_I) w_valid_n = 1'b0;
        if (r_commit) begin
            if (!r_valid || RX_READY_I) begin
                w_valid_n = 1'b1;
                w_data_n  = r_asm;
            end else begin
                w_ovr_n = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            r_sync_meta <= 1'b1;
            r_rxs       <= 1'b1;
            r_state     <= ST_IDLE;
            r_bit_clk   <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_byte      <= '0;
            r_par_err   <= 1'b0;
            r_asm       <= '0;
            r_to_cnt    <= '0;
            r_commit    <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_ferr      <= 1'b0;
            r_perr      <= 1'b0;
            r_ovr       <= 1'b0;
            r_tout      <= 1'b0;
        end else begin
            r_sync_meta <= UART_RX_I;
            r_rxs       <= r_sync_meta;
            r_state     <= w_state_n;
            r_bit_clk   <= w_bit_clk_n;
            r_bit_idx   <= w_bit_idx_n;
            r_byte_idx  <= w_byte_idx_n;
            r_byte      <= w_byte_n;
            r_par_err   <= w_par_err_n;
            r_asm       <= w_asm_n;
            r_to_cnt    <= w_to_cnt_n;
            r_commit    <= w_commit_n;
            r_valid     <= w_valid_n;
            r_data      <= w_data_n;
            r_ferr      <= w_ferr_n;
            r_perr      <= w_perr_n;
            r_ovr       <= w_ovr_n;
            r_tout      <= w_tout_n;
        end
    end

    assign RX_VALID_O   = r_valid;
    assign RX_DATA_O    = r_data;
    assign FRAME_ERR_O  = r_ferr;
    assign PARITY_ERR_O = r_perr;
    assign OVERRUN_O    = r_ovr;
    assign TIMEOUT_O    = r_tout;
    assign BUSY_O       = (r_state != ST_IDLE) | (r_byte_idx != '0);

endmodule

// File: tb/tb_fp32_uart_frame_rx.sv
// Bench for fp32_uart_frame_rx: a 12-byte no-parity instance and a 4-byte
// even-parity instance, checked against a byte-list frame model.
module tb_fp32_uart_frame_rx;

    localparam int C   = 8;
    localparam int FBA = 12;
    localparam int FBB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line_a = 1'b1, line_b = 1'b1;
    logic ready_a;
    logic ready_b = 1'b1;
    int   ready_mode_a = 1;

    logic            valid_a, ferr_a, perr_a, ovr_a, tout_a, busy_a;
    logic [8*FBA-1:0] data_a;
    logic            valid_b, ferr_b, perr_b, ovr_b, tout_b, busy_b;
    logic [8*FBB-1:0] data_b;

    fp32_uart_frame_rx #(
        .CLKS_PER_BIT(C), .FRAME_BYTES(FBA), .PARITY_EN(1'b0),
        .PARITY_ODD(1'b0), .TIMEOUT_BITS(20)
    ) u_dut_a (
        .CLK_I(clk), .RSTL_I(rst_n), .UART_RX_I(line_a), .RX_READY_I(ready_a),
        .RX_VALID_O(valid_a), .RX_DATA_O(data_a), .FRAME_ERR_O(ferr_a),
        .PARITY_ERR_O(perr_a), .OVERRUN_O(ovr_a), .TIMEOUT_O(tout_a), .BUSY_O(busy_a)
    );

    fp32_uart_frame_rx #(
        .CLKS_PER_BIT(C), .FRAME_BYTES(FBB), .PARITY_EN(1'b1),
        .PARITY_ODD(1'b0), .TIMEOUT_BITS(20)
    ) u_dut_b (
        .CLK_I(clk), .RSTL_I(rst_n), .UART_RX_I(line_b), .RX_READY_I(ready_b),
        .RX_VALID_O(valid_b), .RX_DATA_O(data_b), .FRAME_ERR_O(ferr_b),
        .PARITY_ERR_O(perr_b), .OVERRUN_O(ovr_b), .TIMEOUT_O(tout_b), .BUSY_O(busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the partial frame, and frames expected out.
    logic [7:0]       part_a[$], part_b[$];
    logic [8*FBA-1:0] exp_a[$], got_a[$];
    logic [8*FBB-1:0] exp_b[$], got_b[$];
    int exp_ferr_a = 0, exp_tout_a = 0;
    int exp_ferr_b = 0, exp_perr_b = 0, exp_ovr_b = 0;
    int n_ferr_a = 0, n_perr_a = 0, n_ovr_a = 0, n_tout_a = 0;
    int n_ferr_b = 0, n_perr_b = 0, n_ovr_b = 0, n_tout_b = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_busy;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    initial begin
        ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode_a)
                0:       ready_a = 1'b0;
                1:       ready_a = 1'b1;
                default: ready_a = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: counts pulses, captures accepted frames, checks held data stays put.
    initial begin
        logic hold_a, hold_b;
        logic [8*FBA-1:0] hd_a;
        logic [8*FBB-1:0] hd_b;
        hold_a = 1'b0; hold_b = 1'b0; hd_a = '0; hd_b = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_a = 1'b0;
                hold_b = 1'b0;
            end else begin
                if (ferr_a) n_ferr_a++;
                if (perr_a) n_perr_a++;
                if (ovr_a)  n_ovr_a++;
                if (tout_a) n_tout_a++;
                if (ferr_b) n_ferr_b++;
                if (perr_b) n_perr_b++;
                if (ovr_b)  n_ovr_b++;
                if (tout_b) n_tout_b++;
                if (hold_a) check("hold_a", {valid_a, data_a}, {1'b1, hd_a});
                if (hold_b) check("hold_b", {valid_b, data_b}, {1'b1, hd_b});
                if (valid_a && ready_a) got_a.push_back(data_a);
                if (valid_b && ready_b) got_b.push_back(data_b);
                hold_a = valid_a && !ready_a;
                hold_b = valid_b && !ready_b;
                hd_a = data_a;
                hd_b = data_b;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_good_a(input logic [7:0] d);
        logic [8*FBA-1:0] f;
        part_a.push_back(d);
        if (part_a.size() == FBA) begin
            f = '0;
            foreach (part_a[k]) f[8*k +: 8] = part_a[k];
            exp_a.push_back(f);
            part_a.delete();
        end
    endfunction

    function automatic void model_good_b(input logic [7:0] d);
        logic [8*FBB-1:0] f;
        part_b.push_back(d);
        if (part_b.size() == FBB) begin
            f = '0;
            foreach (part_b[k]) f[8*k +: 8] = part_b[k];
            exp_b.push_back(f);
            part_b.delete();
        end
    endfunction

    task automatic drive(input int which, input logic v, input int cyc);
        if (which == 0) line_a = v; else line_b = v;
        repeat (cyc) @(negedge clk);
    endtask

    // Line is left at the stop level; callers restore idle after a low stop.
    task automatic send_char(input int which, input logic [7:0] d, input logic par,
                             input logic stop, input int stop_cyc);
        drive(which, 1'b0, C);
        for (int i = 0; i < 8; i++) drive(which, d[i], C);
        if (which == 1) drive(which, par, C);
        drive(which, stop, stop_cyc);
    endtask

    task automatic send_raw(input int which, input logic [7:0] d);
        send_char(which, d, ^d, 1'b1, C);
    endtask

    task automatic send_good(input int which, input logic [7:0] d);
        send_raw(which, d);
        if (which == 0) model_good_a(d); else model_good_b(d);
    endtask

    task automatic send_frame_a();
        for (int i = 0; i < FBA; i++) send_good(0, 8'($urandom));
    endtask

    task automatic check_all();
        drive(0, 1'b1, 3 * C);
        check("frames_a_count", got_a.size(), exp_a.size());
        for (int k = 0; k < got_a.size() && k < exp_a.size(); k++)
            check("frame_a_data", got_a[k], exp_a[k]);
        check("frames_b_count", got_b.size(), exp_b.size());
        for (int k = 0; k < got_b.size() && k < exp_b.size(); k++)
            check("frame_b_data", got_b[k], exp_b[k]);
        check("ferr_a_count", n_ferr_a, exp_ferr_a);
        check("perr_a_count", n_perr_a, 0);
        check("ovr_a_count",  n_ovr_a, 0);
        check("tout_a_count", n_tout_a, exp_tout_a);
        check("ferr_b_count", n_ferr_b, exp_ferr_b);
        check("perr_b_count", n_perr_b, exp_perr_b);
        check("ovr_b_count",  n_ovr_b, exp_ovr_b);
        check("tout_b_count", n_tout_b, 0);
        got_a.delete(); exp_a.delete();
        got_b.delete(); exp_b.delete();
    endtask

    initial begin
        int   waited, pe0, fe0, ov0, r;
        bit   seen;
        logic [8*FBA-1:0] t1_frame;

        tbl[0] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_valid_a", valid_a, 1'b0);
        check("rst_data_a", data_a, '0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_pulses_a", {ferr_a, perr_a, ovr_a, tout_a}, 4'b0);
        check("rst_valid_b", valid_b, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back 0x00..0x0B
        for (int i = 0; i < FBA; i++) send_good(0, 8'(i));
        drive(0, 1'b1, 3 * C);
        t1_frame = (got_a.size() > 0) ? got_a[0] : '0;
        check("seq_frame_count", got_a.size(), 1);
        check("seq_frame_value", t1_frame, 96'h0B0A09080706050403020100);
        check_all();

        // Short glitch on idle line
        drive(0, 1'b0, 2);
        drive(0, 1'b1, 2 * C);
        check("glitch_busy", busy_a, 1'b0);
        send_frame_a();
        check_all();

        // Stop bit low, line held low in RECOVER
        send_good(0, 8'hA1);
        send_good(0, 8'hB2);
        fe0 = n_ferr_a;
        send_char(0, 8'h55, 1'b0, 1'b0, 30);
        check("ferr_pulse", n_ferr_a - fe0, 1);
        check("recover_busy", busy_a, 1'b1);
        drive(0, 1'b1, C);
        check("recover_exit_busy", busy_a, 1'b0);
        part_a.delete();
        exp_ferr_a++;
        send_frame_a();
        check_all();

        // Inter-byte timeout
        for (int i = 0; i < 5; i++) send_good(0, 8'($urandom));
        check("partial_busy", busy_a, 1'b1);
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 400) begin
            @(negedge clk);
            waited++;
            if (tout_a) seen = 1'b1;
        end
        check("timeout_seen", seen, 1'b1);
        check("timeout_window", (waited >= 150 && waited <= 170), 1'b1);
        @(negedge clk);
        check("timeout_busy", busy_a, 1'b0);
        part_a.delete();
        exp_tout_a++;
        send_frame_a();
        check_all();

        // Parity / stop vectors on the 4-byte parity instance
        for (int i = 0; i < 10; i++) begin
            pe0 = n_perr_b;
            fe0 = n_ferr_b;
            send_char(1, tbl[i].d, tbl[i].par, tbl[i].stop, C);
            drive(1, 1'b1, 2 * C);
            check("tbl_perr", n_perr_b - pe0, tbl[i].exp_perr);
            check("tbl_ferr", n_ferr_b - fe0, tbl[i].exp_ferr);
            check("tbl_busy", busy_b, tbl[i].exp_busy);
            if (tbl[i].exp_perr || tbl[i].exp_ferr) part_b.delete();
            else model_good_b(tbl[i].d);
            exp_perr_b += int'(tbl[i].exp_perr);
            exp_ferr_b += int'(tbl[i].exp_ferr);
        end
        check_all();

        // Overrun while the holding register is full
        @(posedge clk); #1 ready_b = 1'b0;
        @(negedge clk);
        send_raw(1, 8'h00); send_raw(1, 8'h00); send_raw(1, 8'h80); send_raw(1, 8'h3F);
        drive(1, 1'b1, 2 * C);
        check("ovr_first_valid", valid_b, 1'b1);
        check("ovr_first_data", data_b, 32'h3F800000);
        ov0 = n_ovr_b;
        send_raw(1, 8'h00); send_raw(1, 8'h00); send_raw(1, 8'h00); send_raw(1, 8'h40);
        drive(1, 1'b1, 2 * C);
        check("ovr_pulse", n_ovr_b - ov0, 1);
        check("ovr_kept_valid", valid_b, 1'b1);
        check("ovr_kept_data", data_b, 32'h3F800000);
        @(posedge clk); #1 ready_b = 1'b1;
        @(posedge clk); #1 ready_b = 1'b0;
        @(negedge clk);
        check("ovr_valid_cleared", valid_b, 1'b0);
        exp_b.push_back(32'h3F800000);
        exp_ovr_b++;
        @(posedge clk); #1 ready_b = 1'b1;
        @(negedge clk);
        check_all();

        // Randomised traffic with random downstream stalls
        ready_mode_a = 2;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 39);
            if (r == 0) begin
                drive(0, 1'b0, 2);
                drive(0, 1'b1, 12);
            end else if (r == 1) begin
                send_char(0, 8'($urandom), 1'b0, 1'b0, 30);
                drive(0, 1'b1, C);
                part_a.delete();
                exp_ferr_a++;
            end else if (r == 2) begin
                drive(0, 1'b1, 200);
                if (part_a.size() > 0) begin
                    exp_tout_a++;
                    part_a.delete();
                end
            end else begin
                send_good(0, 8'($urandom));
                drive(0, 1'b1, $urandom_range(0, 20));
            end
        end
        ready_mode_a = 1;
        drive(0, 1'b1, 4 * C);
        check_all();

        // Reset in the middle of a character with a frame held
        ready_mode_a = 0;
        drive(0, 1'b1, 2);
        send_frame_a();
        drive(0, 1'b1, 2 * C);
        check("pre_reset_valid", valid_a, 1'b1);
        drive(0, 1'b0, C);
        drive(0, 1'b1, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_valid", valid_a, 1'b0);
        check("mid_reset_data", data_a, '0);
        check("mid_reset_busy", busy_a, 1'b0);
        check("mid_reset_pulses", {ferr_a, perr_a, ovr_a, tout_a}, 4'b0);
        exp_a.delete();
        part_a.delete();
        line_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ready_mode_a = 1;
        repeat (2) @(negedge clk);
        send_frame_a();
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
